// File: rtl/mul_pkg.sv
// Shared op encodings and signedness helpers for the arbitrated multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_MUL    = 2'd0,
    MUL_MULH   = 2'd1,
    MUL_MULHSU = 2'd2,
    MUL_MULHU  = 2'd3
  } mul_op_t;

  function automatic logic op_signed_a(input mul_op_t op);
    return (op == MUL_MULH) || (op == MUL_MULHSU);
  endfunction

  function automatic logic op_signed_b(input mul_op_t op);
    return op == MUL_MULH;
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// Operand extension, multiply and PIPE_STAGES-deep result pipeline with a
// global stall; every stage carries valid, id, op and the full product.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned ID_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [ID_W-1:0]       in_id,
  input  mul_op_t               in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  output logic [ID_W-1:0]       out_id,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned PW   = 2 * DATA_WIDTH;
  localparam int unsigned LAST = PIPE_STAGES - 1;

  logic [PW-1:0] a_w;
  logic [PW-1:0] b_w;
  logic [PW-1:0] prod;

  logic            st_valid [PIPE_STAGES];
  logic [ID_W-1:0] st_id    [PIPE_STAGES];
  mul_op_t         st_op    [PIPE_STAGES];
  logic [PW-1:0]   st_prod  [PIPE_STAGES];

  // Extending to 2W bits and keeping the low 2W bits of the product equals
  // the (W+1)-bit signed/unsigned product, without any signed arithmetic.
  always_comb begin
    a_w  = {{DATA_WIDTH{op_signed_a(in_op) & in_a[DATA_WIDTH-1]}}, in_a};
    b_w  = {{DATA_WIDTH{op_signed_b(in_op) & in_b[DATA_WIDTH-1]}}, in_b};
    prod = a_w * b_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        st_valid[s] <= 1'b0;
        st_id[s]    <= '0;
        st_op[s]    <= MUL_MUL;
        st_prod[s]  <= '0;
      end
    end else if (!stall) begin
      st_valid[0] <= in_valid;
      st_id[0]    <= in_id;
      st_op[0]    <= in_op;
      st_prod[0]  <= prod;
      for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_id[s]    <= st_id[s-1];
        st_op[s]    <= st_op[s-1];
        st_prod[s]  <= st_prod[s-1];
      end
    end
  end

  always_comb begin
    out_valid = st_valid[LAST];
    out_id    = st_id[LAST];
    out_data  = (st_op[LAST] == MUL_MUL) ? st_prod[LAST][DATA_WIDTH-1:0]
                                         : st_prod[LAST][PW-1:DATA_WIDTH];
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding a shared pipelined multiplier; the pipeline
// advances only when the response slot is empty or being consumed.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  mul_op_t [NUM_REQ-1:0]               req_op,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]          resp_id,
  output logic [DATA_WIDTH-1:0]               resp_data,
  input  logic                                resp_ready
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic            advance;
  logic            found;
  logic            grant;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  int unsigned     idx;

  assign advance = !resp_valid || resp_ready;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant     = advance && found && !rst;
    req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
    ptr_next  = ID_W'((32'(winner) + 32'd1) % NUM_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= ptr_next;
    end
  end

  mul_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .PIPE_STAGES(PIPE_STAGES),
    .ID_W       (ID_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .stall    (!advance),
    .in_valid (grant),
    .in_id    (winner),
    .in_op    (req_op[winner]),
    .in_a     (req_a[winner]),
    .in_b     (req_b[winner]),
    .out_valid(resp_valid),
    .out_id   (resp_id),
    .out_data (resp_data)
  );

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: reset, latency, signedness, fairness,
// backpressure and mid-flight reset, with an in-order response scoreboard.
module tb_mul_arbiter;
  import mul_pkg::*;

  localparam int unsigned W = 64;
  localparam int unsigned N = 4;
  localparam int unsigned P = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          req_valid = '0;
  mul_op_t [N-1:0]       req_op;
  logic [N-1:0][W-1:0]   req_a;
  logic [N-1:0][W-1:0]   req_b;
  logic [N-1:0]          req_ready;
  logic                  resp_valid;
  logic [1:0]            resp_id;
  logic [W-1:0]          resp_data;
  logic                  resp_ready = 1'b1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] data;
  } resp_t;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  mul_arbiter #(
    .DATA_WIDTH (W),
    .NUM_REQ    (N),
    .PIPE_STAGES(P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .resp_ready(resp_ready)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic [1:0] id, input logic [W-1:0] d);
    exp_q.push_back(resp_t'{id: id, data: d});
  endtask

  // Every response transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    resp_t e;
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", W'(resp_valid), '0);
      end else begin
        e = exp_q.pop_front();
        check("resp_id", W'(resp_id), W'(e.id));
        check("resp_data", resp_data, e.data);
      end
    end
  end

  mul_op_t      v_op  [6];
  logic [W-1:0] v_a   [6];
  logic [W-1:0] v_b   [6];
  logic [W-1:0] v_exp [6];

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      req_op[i] = MUL_MUL;
      req_a[i]  = '0;
      req_b[i]  = '0;
    end

    // Reset state with every requester asking
    req_valid = '1;
    repeat (2) tick();
    check("rst_req_ready",  W'(req_ready),  '0);
    check("rst_resp_valid", W'(resp_valid), '0);
    check("rst_resp_id",    W'(resp_id),    '0);
    check("rst_resp_data",  resp_data,      '0);

    // Single MUL from requester 2, accepted on the first edge after reset
    rst       = 1'b0;
    req_valid = 4'b0100;
    req_op[2] = MUL_MUL;
    req_a[2]  = 64'd3;
    req_b[2]  = 64'd5;
    #1;
    check("single_ready", W'(req_ready), W'(4'b0100));
    expect_resp(2'd2, 64'd15);
    tick();
    req_valid = '0;
    check("single_lat_k", W'(resp_valid), '0);
    tick();
    check("single_lat_k1", W'(resp_valid), 64'd1);
    check("single_id",     W'(resp_id),    64'd2);
    check("single_data",   resp_data,      64'd15);
    tick();

    // Signedness and width boundaries, all from requester 0
    v_op[0] = MUL_MULH;   v_a[0] = '1;                    v_b[0] = '1;                    v_exp[0] = 64'h0;
    v_op[1] = MUL_MULHSU; v_a[1] = '1;                    v_b[1] = '1;                    v_exp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    v_op[2] = MUL_MULHU;  v_a[2] = '1;                    v_b[2] = '1;                    v_exp[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    v_op[3] = MUL_MULH;   v_a[3] = 64'h8000_0000_0000_0000; v_b[3] = 64'h8000_0000_0000_0000; v_exp[3] = 64'h4000_0000_0000_0000;
    v_op[4] = MUL_MUL;    v_a[4] = '1;                    v_b[4] = '1;                    v_exp[4] = 64'h1;
    v_op[5] = MUL_MUL;    v_a[5] = 64'hFFFF_FFFF_FFFF_FFFE; v_b[5] = 64'd3;               v_exp[5] = 64'hFFFF_FFFF_FFFF_FFFA;
    for (int k = 0; k < 6; k++) begin
      req_valid = 4'b0001;
      req_op[0] = v_op[k];
      req_a[0]  = v_a[k];
      req_b[0]  = v_b[k];
      #1;
      check("sign_ready", W'(req_ready), W'(4'b0001));
      expect_resp(2'd0, v_exp[k]);
      tick();
    end
    req_valid = '0;
    repeat (4) tick();

    // Reset with two requests in flight (pointer is at 1 here)
    req_valid = 4'b1010;
    #1;
    check("rmf_grant_a", W'(req_ready), W'(4'b0010));
    tick();
    check("rmf_grant_b", W'(req_ready), W'(4'b1000));
    tick();
    req_valid = '0;
    rst       = 1'b1;
    #1;
    check("rmf_resp_valid", W'(resp_valid), '0);
    check("rmf_resp_id",    W'(resp_id),    '0);
    check("rmf_resp_data",  resp_data,      '0);
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rmf_no_stale", W'(resp_valid), '0);
    end

    // Fairness: all requesters valid, one grant per cycle in rotation
    for (int i = 0; i < int'(N); i++) begin
      req_op[i] = MUL_MUL;
      req_a[i]  = W'(i + 1);
      req_b[i]  = 64'd10;
    end
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("fair_grant", W'(req_ready), W'(64'd1 << (c % 4)));
      expect_resp(2'(c % 4), W'(10 * (c % 4 + 1)));
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Backpressure: fill the pipeline, then hold the consumer off for 5 cycles
    resp_ready = 1'b0;
    req_valid  = '1;
    #1;
    check("bp_grant0", W'(req_ready), W'(4'b0001));
    expect_resp(2'd0, 64'd10);
    tick();
    check("bp_grant1", W'(req_ready), W'(4'b0010));
    expect_resp(2'd1, 64'd20);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_ready_zero", W'(req_ready),  '0);
      check("bp_valid_hold", W'(resp_valid), 64'd1);
      check("bp_id_hold",    W'(resp_id),    '0);
      check("bp_data_hold",  resp_data,      64'd10);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    check("queue_drained", W'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the operand width.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-003 The block SHALL have parameter PIPE_STAGES, default 2, giving the multiply pipeline depth (1..4).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; their ports are clk and rst.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active high
- req_valid  in  NUM_REQ  per-requester request valid
- req_op  in  NUM_REQ x 2  per-requester op (mul_op_t)
- req_a  in  NUM_REQ x DATA_WIDTH  per-requester operand A
- req_b  in  NUM_REQ x DATA_WIDTH  per-requester operand B
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- resp_valid  out  1  result valid
- resp_id  out  clog2(NUM_REQ)  index of the requester that issued the result
- resp_data  out  DATA_WIDTH  selected product half
- resp_ready  in  1  consumer accept

Function
REQ-005 A transfer on requester i SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both high; a transfer on the response SHALL occur where resp_valid and resp_ready are both high.
REQ-006 The pipeline SHALL advance when advance = !resp_valid || resp_ready; when advance is low, every stage SHALL hold its contents.
REQ-007 req_ready[i] SHALL be high only when advance is high and i is the round-robin winner among the requesters with req_valid high; at most one req_ready bit SHALL be high per cycle.
REQ-008 Arbitration SHALL be round-robin: the search starts at pointer ptr; after a grant to i, ptr SHALL become (i+1) mod NUM_REQ; with no grant, ptr SHALL hold.
REQ-009 req_ready SHALL depend combinationally on req_valid, ptr and the pipeline state, and SHALL NOT depend on req_op, req_a or req_b.
REQ-010 Ops (mul_op_t) SHALL be: MUL=0 (low half), MULH=1 (high half, signed x signed), MULHSU=2 (high half, signed A x unsigned B), MULHU=3 (high half, unsigned x unsigned).
REQ-011 The product SHALL be computed on (DATA_WIDTH+1)-bit operands, each extended per its signedness; resp_data SHALL be bits [W-1:0] for MUL and bits [2W-1:W] otherwise.
REQ-012 A request accepted on edge k SHALL make resp_valid high in the cycle after edge k+PIPE_STAGES-1 when no stall occurs; each stall cycle SHALL add exactly one cycle.
REQ-013 Every stage SHALL carry a valid bit, the id and the op with its data; resp_valid SHALL be the valid bit of the last stage.
REQ-014 Responses SHALL be delivered in acceptance order; no request SHALL be dropped or duplicated.
REQ-015 resp_valid, resp_id and resp_data SHALL stay stable while resp_valid is high and resp_ready is low.
REQ-016 With resp_ready held high, the block SHALL sustain one acceptance per cycle.
REQ-017 The MUL result SHALL be identical for signed and unsigned interpretations of the operands.
REQ-018 Width boundaries: MULHU of all-ones x all-ones SHALL yield all-ones minus 1; MULH of the most-negative value x the most-negative value SHALL yield 2^(W-2).

Reset
REQ-019 While rst is high, all stage valid bits, resp_valid and ptr SHALL be 0, and req_ready SHALL be all-zero.
REQ-020 An assertion of rst mid-operation SHALL discard all in-flight requests without a response; resp_id and resp_data SHALL reset to 0.
REQ-021 On the first edge after rst deasserts, the block SHALL be able to accept a request.

Structure
REQ-022 The mul_op_t enum and the MUL_* encodings SHALL live in a shared package mul_pkg.
REQ-023 The operand-extension and multiply stage SHALL be a sub-module mul_pipe, parameterised by DATA_WIDTH and PIPE_STAGES, with a stall input; mul_arbiter SHALL hold the arbiter and the handshake logic.

Verification
REQ-024 Single MUL, W=64: requester 2 sends A=3, B=5, resp_ready=1 -> resp_valid in the cycle after edge k+1, resp_id=2, resp_data=15.
REQ-025 Signedness: MULH, MULHSU and MULHU with A=B=0xFFFF_FFFF_FFFF_FFFF -> 0x0, 0xFFFF_FFFF_FFFF_FFFF and 0xFFFF_FFFF_FFFF_FFFE respectively.
REQ-026 Fairness: all 4 requesters hold valid with resp_ready=1 -> grants 0,1,2,3,0,... in consecutive cycles, one response per cycle, ids in the same order.
REQ-027 Backpressure: resp_ready held low for 5 cycles while the pipeline is full -> req_ready all-zero and outputs stable; after release, responses arrive in order with none lost.
REQ-028 Reset mid-flight: rst asserted with 2 requests in flight -> resp_valid=0 immediately, no stale responses after release, and the first grant after release goes to requester 0.
